// File: rtl/pid_move_sequencer.sv
// Trapezoidal move sequencer: generates a ramped position setpoint for a PID loop and waits for settle.
// Optional macro SETTLE_TIMEOUT_EN adds a settle timeout with sticky timeout_err.
module pid_move_sequencer #(
  parameter int DIV           = 10,
  parameter int SETTLE_WIN    = 1000,
  parameter int SETTLE_CNT    = 16,
  parameter int TIMEOUT_TICKS = 10000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic signed [31:0] cmd_target,
  input  logic [15:0]        cmd_vmax,
  input  logic [15:0]        cmd_acc,
  input  logic               abort,
  input  logic signed [31:0] actual_pos,
  output logic signed [31:0] desired_pos,
  output logic               busy,
  output logic               done,
  output logic [2:0]         state_o,
  output logic               timeout_err
);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW = $clog2(SETTLE_CNT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEL  = 3'd1,
    S_CRUISE = 3'd2,
    S_DECEL  = 3'd3,
    S_SETTLE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [DW-1:0]      div_q;
  logic               tick;
  logic signed [31:0] pos_q, pos_d, tgt_q, tgt_d;
  logic [15:0]        vmax_q, vmax_d, acc_q, acc_d;
  logic               dir_neg_q, dir_neg_d;
  logic [16:0]        vel_q, vel_d;
  logic [32:0]        ramp_q, ramp_d;
  logic [SW-1:0]      settle_q, settle_d;
  logic               done_q, done_d;

  logic [32:0] diff, rem, cmd_diff, pos_err, pos_err_abs, step;
  logic [16:0] vel_acc, vel_new;
  logic [33:0] ramp_sum;
  logic [31:0] pos_next;
  logic        in_win, move, ramp_en;

`ifdef SETTLE_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
  logic        terr_q, terr_d;
`endif

  assign tick        = (div_q == DW'(DIV - 1));
  assign diff        = {tgt_q[31], tgt_q} - {pos_q[31], pos_q};
  assign rem         = diff[32] ? (33'd0 - diff) : diff;
  assign cmd_diff    = {cmd_target[31], cmd_target} - {pos_q[31], pos_q};
  assign pos_err     = {tgt_q[31], tgt_q} - {actual_pos[31], actual_pos};
  assign pos_err_abs = pos_err[32] ? (33'd0 - pos_err) : pos_err;
  assign in_win      = (pos_err_abs <= 33'(SETTLE_WIN));
  assign vel_acc     = vel_q + {1'b0, acc_q};

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    tgt_d     = tgt_q;
    vmax_d    = vmax_q;
    acc_d     = acc_q;
    dir_neg_d = dir_neg_q;
    vel_d     = vel_q;
    ramp_d    = ramp_q;
    settle_d  = settle_q;
    done_d    = 1'b0;
    vel_new   = vel_q;
    move      = 1'b0;
    ramp_en   = 1'b0;
    step      = '0;
    ramp_sum  = '0;
    pos_next  = pos_q;
`ifdef SETTLE_TIMEOUT_EN
    tmo_d     = tmo_q;
    terr_d    = terr_q;
`endif
    if (state_q != S_IDLE && abort) begin
      // Abort freezes the setpoint where it is; the command is dropped silently.
      state_d  = S_IDLE;
      vel_d    = '0;
      ramp_d   = '0;
      settle_d = '0;
    end else if (state_q == S_IDLE) begin
      if (cmd_valid && cmd_ready) begin
        tgt_d     = cmd_target;
        vmax_d    = (cmd_vmax == 16'd0) ? 16'd1 : cmd_vmax;
        acc_d     = (cmd_acc == 16'd0) ? 16'd1 : cmd_acc;
        dir_neg_d = cmd_diff[32];
        vel_d     = '0;
        ramp_d    = '0;
        settle_d  = '0;
        state_d   = (cmd_diff == 33'd0) ? S_SETTLE : S_ACCEL;
`ifdef SETTLE_TIMEOUT_EN
        tmo_d     = '0;
        terr_d    = 1'b0;
`endif
      end
    end else if (tick) begin
      case (state_q)
        S_ACCEL: begin
          if (rem <= ramp_q) begin
            state_d = S_DECEL;
          end else begin
            vel_new = (vel_acc < {1'b0, vmax_q}) ? vel_acc : {1'b0, vmax_q};
            move    = 1'b1;
            ramp_en = 1'b1;
            if (vel_new == {1'b0, vmax_q}) state_d = S_CRUISE;
          end
        end
        S_CRUISE: begin
          if (rem <= ramp_q) state_d = S_DECEL;
          else               move    = 1'b1;
        end
        S_DECEL: begin
          vel_new = (vel_q > {1'b0, acc_q}) ? (vel_q - {1'b0, acc_q}) : 17'd1;
          move    = 1'b1;
        end
        S_SETTLE: begin
          if (in_win) begin
            if (settle_q == SW'(SETTLE_CNT - 1)) begin
              state_d  = S_IDLE;
              done_d   = 1'b1;
              settle_d = '0;
            end else begin
              settle_d = settle_q + SW'(1);
            end
          end else begin
            settle_d = '0;
          end
`ifdef SETTLE_TIMEOUT_EN
          if (state_d == S_SETTLE) begin
            if (tmo_q == 32'(TIMEOUT_TICKS - 1)) begin
              terr_d   = 1'b1;
              state_d  = S_IDLE;
              settle_d = '0;
            end else begin
              tmo_d = tmo_q + 32'd1;
            end
          end
`endif
        end
        default: state_d = S_IDLE;
      endcase

      if (move) begin
        step  = ({16'd0, vel_new} < rem) ? {16'd0, vel_new} : rem;
        vel_d = vel_new;
        if (ramp_en) begin
          ramp_sum = {1'b0, ramp_q} + {1'b0, step};
          ramp_d   = ramp_sum[33] ? '1 : ramp_sum[32:0];
        end
        // A step can never exceed the remaining distance, so 32-bit wrap cannot occur.
        pos_next = dir_neg_q ? (pos_q - step[31:0]) : (pos_q + step[31:0]);
        pos_d    = pos_next;
        if (step == rem) begin
          state_d  = S_SETTLE;
          settle_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      pos_q     <= '0;
      tgt_q     <= '0;
      vmax_q    <= '0;
      acc_q     <= '0;
      dir_neg_q <= 1'b0;
      vel_q     <= '0;
      ramp_q    <= '0;
      settle_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= tick ? '0 : (div_q + DW'(1));
      pos_q     <= pos_d;
      tgt_q     <= tgt_d;
      vmax_q    <= vmax_d;
      acc_q     <= acc_d;
      dir_neg_q <= dir_neg_d;
      vel_q     <= vel_d;
      ramp_q    <= ramp_d;
      settle_q  <= settle_d;
      done_q    <= done_d;
    end
  end

`ifdef SETTLE_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      tmo_q  <= tmo_d;
      terr_q <= terr_d;
    end
  end
  assign timeout_err = terr_q;
`else
  logic unused_cfg;
  assign unused_cfg  = ^TIMEOUT_TICKS;
  assign timeout_err = 1'b0;
`endif

  assign cmd_ready   = (state_q == S_IDLE) && !abort;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign state_o     = state_q;
  assign desired_pos = pos_q;
endmodule
